// File: rtl/darkbus_arb.sv
// Two-master data-bus arbiter: round-robin owner selection, lane byte-enables, per-core HLT stall.
// Latency: DAS seen in IDLE -> M_REQ next cycle; M_ACK -> owner DATAI valid and HLT low next cycle.
// Backpressure: requesters are stalled via Rn_HLT until their access ends; a hung access aborts after TIMEOUT.
module darkbus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              R0_DAS,
    input  logic              R0_DRD,
    input  logic              R0_DWR,
    input  logic [ADDR_W-1:0] R0_DADDR,
    input  logic [DATA_W-1:0] R0_DATAO,
    input  logic [2:0]        R0_DLEN,
    output logic [DATA_W-1:0] R0_DATAI,
    output logic              R0_HLT,
    input  logic              R1_DAS,
    input  logic              R1_DRD,
    input  logic              R1_DWR,
    input  logic [ADDR_W-1:0] R1_DADDR,
    input  logic [DATA_W-1:0] R1_DATAO,
    input  logic [2:0]        R1_DLEN,
    output logic [DATA_W-1:0] R1_DATAI,
    output logic              R1_HLT,
    output logic              M_REQ,
    output logic              M_WR,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    output logic [3:0]        M_BE,
    input  logic [DATA_W-1:0] M_RDATA,
    input  logic              M_ACK,
    output logic [1:0]        GNT,
    output logic              ERR
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_wr_q, m_wr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] datai0_q, datai0_d;
    logic [DATA_W-1:0] datai1_q, datai1_d;

    logic              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_len;

    // Read qualifier carries no information: anything not a write is a read.
    logic unused_rd;
    assign unused_rd = R0_DRD ^ R1_DRD;

    function automatic logic [3:0] lane_be(input logic [2:0] len, input logic [1:0] a);
        case (len)
            3'd1:    return 4'b0001 << a;
            3'd2:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Lone requester wins; on a tie the one not served last wins.
    assign sel      = (R0_DAS & R1_DAS) ? ~last_q : R1_DAS;
    assign sel_addr = sel ? R1_DADDR : R0_DADDR;
    assign sel_len  = sel ? R1_DLEN  : R0_DLEN;

    // Next-state, bus latch, timeout and read-data capture.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_wr_d    = m_wr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        gnt_d     = gnt_q;
        err_d     = 1'b0;
        datai0_d  = datai0_q;
        datai1_d  = datai1_q;
        case (state_q)
            ST_IDLE: begin
                if (R0_DAS | R1_DAS) begin
                    state_d   = ST_BUSY;
                    owner_d   = sel;
                    last_d    = sel;
                    cnt_d     = 8'd0;
                    m_req_d   = 1'b1;
                    m_wr_d    = sel ? R1_DWR : R0_DWR;
                    m_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
                    m_wdata_d = sel ? R1_DATAO : R0_DATAO;
                    m_be_d    = lane_be(sel_len, sel_addr[1:0]);
                    gnt_d     = sel ? 2'b10 : 2'b01;
                end
            end
            ST_BUSY: begin
                // An ACK arriving in the abort cycle still completes normally.
                if (M_ACK) begin
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    if (owner_q) datai1_d = M_RDATA;
                    else         datai0_d = M_RDATA;
                end else if (cnt_q == TO_LIMIT) begin
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (owner_q) datai1_d = DATA_W'(32'hDEADBEEF);
                    else         datai0_d = DATA_W'(32'hDEADBEEF);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 8'd0;
            m_req_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= 4'b0000;
            gnt_q     <= 2'b00;
            err_q     <= 1'b0;
            datai0_q  <= '0;
            datai1_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_wr_q    <= m_wr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
            datai0_q  <= datai0_d;
            datai1_q  <= datai1_d;
        end
    end

    // Stall is combinational so an idle core is never held and the owner is released in RESP.
    assign R0_HLT = R0_DAS & ~((state_q == ST_RESP) & ~owner_q);
    assign R1_HLT = R1_DAS & ~((state_q == ST_RESP) &  owner_q);

    assign R0_DATAI = datai0_q;
    assign R1_DATAI = datai1_q;
    assign M_REQ    = m_req_q;
    assign M_WR     = m_wr_q;
    assign M_ADDR   = m_addr_q;
    assign M_WDATA  = m_wdata_q;
    assign M_BE     = m_be_q;
    assign GNT      = gnt_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_darkbus_arb.sv
// Scoreboard bench for darkbus_arb: stimulus plans each access into a queue, a monitor checks the bus and responses.
// Latency: checks happen on the falling edge; memory responder answers after a planned per-access delay.
// Backpressure: requesters hold DAS until HLT drops, or abandon early to exercise completion without a core.
module tb_darkbus_arb;
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RES = 1'b0;
    logic [1:0]  das = 2'b00, drd = 2'b00, dwr = 2'b00;
    logic [31:0] daddr [2];
    logic [31:0] dato  [2];
    logic [2:0]  dlen  [2];
    logic [31:0] datai0, datai1;
    logic        hlt0, hlt1;
    logic        m_req, m_wr, m_ack, err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic [1:0]  gnt;

    darkbus_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RES(RES),
        .R0_DAS(das[0]), .R0_DRD(drd[0]), .R0_DWR(dwr[0]), .R0_DADDR(daddr[0]),
        .R0_DATAO(dato[0]), .R0_DLEN(dlen[0]), .R0_DATAI(datai0), .R0_HLT(hlt0),
        .R1_DAS(das[1]), .R1_DRD(drd[1]), .R1_DWR(dwr[1]), .R1_DADDR(daddr[1]),
        .R1_DATAO(dato[1]), .R1_DLEN(dlen[1]), .R1_DATAI(datai1), .R1_HLT(hlt1),
        .M_REQ(m_req), .M_WR(m_wr), .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_BE(m_be),
        .M_RDATA(m_rdata), .M_ACK(m_ack), .GNT(gnt), .ERR(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          owner;
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
        int          cyc;
        logic        err;
        logic [31:0] datai;
    } exp_t;
    typedef struct {
        int          dly;
        logic [31:0] rdata;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        rsp_q[$];
    int          dly  [2];
    logic [31:0] rdat [2];
    logic [31:0] m_datai [2];
    int          m_last;
    int          vectors = 0;
    int          miscompares = 0;
    logic        mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic hlt_of(input int n);
        return (n == 0) ? hlt0 : hlt1;
    endfunction

    function automatic logic [31:0] datai_of(input int n);
        return (n == 0) ? datai0 : datai1;
    endfunction

    // Naturally aligned lane window of 1, 2 or 4 bytes.
    function automatic logic [3:0] model_be(input logic [2:0] len, input logic [31:0] addr);
        int nbytes, start;
        nbytes = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
        start  = (int'(addr % 4) / nbytes) * nbytes;
        return 4'(((1 << nbytes) - 1) << start);
    endfunction

    task automatic push_exp(input int n);
        exp_t e;
        rsp_t r;
        e.owner = n;
        e.gnt   = (n == 0) ? 2'b01 : 2'b10;
        e.addr  = daddr[n] & ~32'h3;
        e.be    = model_be(dlen[n], daddr[n]);
        e.wr    = dwr[n];
        e.wdata = dato[n];
        e.err   = dly[n] > TO;
        e.cyc   = e.err ? TO + 1 : dly[n] + 1;
        e.datai = e.err ? 32'hDEADBEEF : rdat[n];
        r.dly   = dly[n];
        r.rdata = rdat[n];
        exp_q.push_back(e);
        rsp_q.push_back(r);
    endtask

    // Service order for a set of simultaneous requests.
    task automatic plan(input logic [1:0] mask);
        int first;
        if (mask == 2'b11) begin
            first = 1 - m_last;
            push_exp(first);
            push_exp(1 - first);
            m_last = 1 - first;
        end else begin
            first = (mask == 2'b10) ? 1 : 0;
            push_exp(first);
            m_last = first;
        end
    endtask

    task automatic rand_fields(input int n);
        daddr[n] = $urandom;
        dato[n]  = $urandom;
        dlen[n]  = 3'($urandom_range(0, 7));
        drd[n]   = 1'($urandom_range(0, 1));
        dwr[n]   = 1'($urandom_range(0, 1));
        dly[n]   = $urandom_range(0, 6);
        rdat[n]  = $urandom;
    endtask

    task automatic serve(input logic drop);
        int first;
        bit done;
        first = (exp_q.size() > 0) ? exp_q[0].owner : 0;
        done  = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge CLK); #1;
            for (int n = 0; n < 2; n++)
                if (das[n] && !hlt_of(n)) das[n] = 1'b0;
            if (drop && das[first] && m_req && gnt == ((first == 0) ? 2'b01 : 2'b10))
                das[first] = 1'b0;
            if (das == 2'b00 && exp_q.size() == 0) done = 1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL batch_timeout: %0d accesses outstanding, expected 0", exp_q.size());
            exp_q.delete();
            rsp_q.delete();
            das = 2'b00;
        end
        @(negedge CLK); #1;
    endtask

    task automatic run_batch(input logic [1:0] mask, input logic rnd, input logic drop);
        for (int n = 0; n < 2; n++)
            if (mask[n] && rnd) rand_fields(n);
        das = mask;
        plan(mask);
        serve(drop);
    endtask

    // Memory side: ACK on the planned cycle of each request, stray ACKs while no request is open.
    initial begin
        rsp_t cur;
        int   rcnt;
        logic r_prev;
        m_ack = 1'b0; m_rdata = '0; r_prev = 1'b0; rcnt = 0;
        cur.dly = 99; cur.rdata = '0;
        forever begin
            @(negedge CLK); #2;
            if (m_req) begin
                if (!r_prev) begin
                    if (rsp_q.size() > 0) cur = rsp_q.pop_front();
                    else begin cur.dly = 99; cur.rdata = '0; end
                    rcnt = 0;
                end
                m_ack   = (rcnt == cur.dly);
                m_rdata = (rcnt == cur.dly) ? cur.rdata : $urandom;
                rcnt++;
            end else begin
                m_ack   = ($urandom_range(0, 3) == 0);
                m_rdata = $urandom;
            end
            r_prev = m_req;
        end
    end

    // Monitor: bus contents on request start, response on the cycle after the request ends, holds otherwise.
    initial begin
        exp_t e;
        logic prev;
        int   run;
        prev = 1'b0; run = 0;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (m_req && !prev) begin
                    run = 1;
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_req: got request expected none at %0t", $time);
                    end else begin
                        chk("req_gnt",   32'(gnt),   32'(exp_q[0].gnt));
                        chk("req_addr",  m_addr,     exp_q[0].addr);
                        chk("req_be",    32'(m_be),  32'(exp_q[0].be));
                        chk("req_wr",    32'(m_wr),  32'(exp_q[0].wr));
                        chk("req_wdata", m_wdata,    exp_q[0].wdata);
                    end
                end else if (m_req) begin
                    run++;
                end
                if (prev && !m_req) begin
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_resp: got response expected none at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_cycles", 32'(run), 32'(e.cyc));
                        chk("resp_err",   32'(err), 32'(e.err));
                        chk("resp_gnt",   32'(gnt), 32'(e.gnt));
                        chk("resp_datai", datai_of(e.owner), e.datai);
                        chk("other_datai", datai_of(1 - e.owner), m_datai[1 - e.owner]);
                        chk("owner_hlt",  32'(hlt_of(e.owner)), 32'd0);
                        chk("other_hlt",  32'(hlt_of(1 - e.owner)), 32'(das[1 - e.owner]));
                        m_datai[e.owner] = e.datai;
                    end
                end else begin
                    chk("err_idle", 32'(err),  32'd0);
                    chk("hlt0",     32'(hlt0), 32'(das[0]));
                    chk("hlt1",     32'(hlt1), 32'(das[1]));
                    chk("datai0_hold", datai0, m_datai[0]);
                    chk("datai1_hold", datai1, m_datai[1]);
                    if (!m_req)                chk("gnt_idle", 32'(gnt), 32'd0);
                    else if (exp_q.size() > 0) chk("gnt_busy", 32'(gnt), 32'(exp_q[0].gnt));
                end
            end
            prev = m_req;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            daddr[n] = '0; dato[n] = '0; dlen[n] = 3'd4; dly[n] = 0; rdat[n] = '0; m_datai[n] = '0;
        end
        m_last = 1;
        das    = 2'b01;
        #3;
        chk("rst_mreq",  32'(m_req), 32'd0);
        chk("rst_mwr",   32'(m_wr),  32'd0);
        chk("rst_maddr", m_addr,     32'd0);
        chk("rst_wdata", m_wdata,    32'd0);
        chk("rst_be",    32'(m_be),  32'd0);
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_datai0", datai0,    32'd0);
        chk("rst_datai1", datai1,    32'd0);
        chk("rst_hlt0",  32'(hlt0),  32'd1);
        chk("rst_hlt1",  32'(hlt1),  32'd0);
        das = 2'b00;
        @(negedge CLK); #1;
        RES = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK); #1;

        // Word read with a one-cycle wait state.
        daddr[0] = 32'h104; dlen[0] = 3'd4; drd[0] = 1'b1; dwr[0] = 1'b0;
        dly[0] = 1; rdat[0] = 32'h12345678; dato[0] = 32'h0;
        run_batch(2'b01, 1'b0, 1'b0);
        // Byte and halfword writes from requester 1.
        daddr[1] = 32'h203; dlen[1] = 3'd1; drd[1] = 1'b1; dwr[1] = 1'b1;
        dly[1] = 0; rdat[1] = 32'hA5A5A5A5; dato[1] = 32'hAB000000;
        run_batch(2'b10, 1'b0, 1'b0);
        daddr[1] = 32'h202; dlen[1] = 3'd2; drd[1] = 1'b0; dwr[1] = 1'b1;
        dly[1] = 2; dato[1] = 32'hCDEF0000;
        run_batch(2'b10, 1'b0, 1'b0);
        // Ties with immediate ACK alternate between requesters.
        for (int t = 0; t < 2; t++) begin
            rand_fields(0); rand_fields(1); dly[0] = 0; dly[1] = 0;
            run_batch(2'b11, 1'b0, 1'b0);
        end
        // Abort with no ACK, and ACK landing exactly in the abort cycle.
        rand_fields(0); dly[0] = 6;
        run_batch(2'b01, 1'b0, 1'b0);
        rand_fields(1); dly[1] = TO;
        run_batch(2'b10, 1'b0, 1'b0);

        for (int b = 0; b < 60; b++)
            run_batch(2'($urandom_range(1, 3)), 1'b1, 1'($urandom_range(0, 4) == 0));

        // Leave requester 0 as last served, then reset in the middle of a tie.
        rand_fields(0);
        run_batch(2'b01, 1'b0, 1'b0);
        mon_en = 1'b0;
        rand_fields(0); rand_fields(1);
        das = 2'b11;
        for (int c = 0; c < 20 && !m_req; c++) begin
            @(negedge CLK); #1;
        end
        chk("pre_rst_req", 32'(m_req), 32'd1);
        #2 RES = 1'b0;
        #1;
        chk("async_mreq", 32'(m_req), 32'd0);
        chk("async_gnt",  32'(gnt),   32'd0);
        chk("async_datai0", datai0,   32'd0);
        chk("async_datai1", datai1,   32'd0);
        chk("async_hlt0", 32'(hlt0),  32'd1);
        chk("async_hlt1", 32'(hlt1),  32'd1);
        exp_q.delete();
        rsp_q.delete();
        m_datai[0] = '0; m_datai[1] = '0;
        m_last = 1;
        @(negedge CLK); #1;
        plan(2'b11);
        chk("rst_tie_winner", 32'(exp_q[0].owner), 32'd0);
        mon_en = 1'b1;
        RES = 1'b1;
        serve(1'b0);
        run_batch(2'b11, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
